// File: rtl/counter_sweep_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// counter_sweep_ctrl_pkg
// Shared definitions for the sweep controller: FSM state encoding, default
// parameter values and a helper that sizes the dwell countdown register.
// -----------------------------------------------------------------------------
package counter_sweep_ctrl_pkg;

  localparam int DEF_WIDTH = 4;  // default counter value width
  localparam int DEF_DWELL = 2;  // default hold cycles at each endpoint
  localparam int LEGS_W    = 3;  // width of legs / leg_idx

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_RUN   = 3'd2,
    ST_DWELL = 3'd3,
    ST_DONE  = 3'd4
  } sweep_state_e;

  // Bits needed to hold the value 'dwell'; never narrower than one bit.
  function automatic int timer_width(input int dwell);
    return (dwell < 2) ? 1 : $clog2(dwell + 1);
  endfunction

endpackage

// File: rtl/counter_sweep_ctrl_if.sv
// -----------------------------------------------------------------------------
// counter_sweep_ctrl_if
// Bundles the sweep request side and the controlled-counter side of the
// sweep controller.
//   master : drives sweep requests and the counter's current value
//   slave  : the controller; drives counter controls and status
// Signals:
//   start, start_value, end_value, legs, abort  - sweep request
//   cnt_count                                   - current counter value
//   cnt_enable, cnt_set, cnt_set_value,
//   cnt_up_down                                 - counter controls
//   busy, done, leg_idx                         - status
// -----------------------------------------------------------------------------
interface counter_sweep_ctrl_if
  import counter_sweep_ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);

  logic              start;
  logic [WIDTH-1:0]  start_value;
  logic [WIDTH-1:0]  end_value;
  logic [LEGS_W-1:0] legs;
  logic              abort;
  logic [WIDTH-1:0]  cnt_count;

  logic              cnt_enable;
  logic              cnt_set;
  logic [WIDTH-1:0]  cnt_set_value;
  logic              cnt_up_down;
  logic              busy;
  logic              done;
  logic [LEGS_W-1:0] leg_idx;

  modport master (
    output start, start_value, end_value, legs, abort, cnt_count,
    input  cnt_enable, cnt_set, cnt_set_value, cnt_up_down, busy, done, leg_idx
  );

  modport slave (
    input  start, start_value, end_value, legs, abort, cnt_count,
    output cnt_enable, cnt_set, cnt_set_value, cnt_up_down, busy, done, leg_idx
  );

endinterface

// File: rtl/counter_sweep_ctrl_dwell_timer.sv
// -----------------------------------------------------------------------------
// sweep_dwell_timer
// Countdown that measures the hold time at a sweep endpoint.
// Ports:
//   clk       - clock
//   reset     - asynchronous active-low reset
//   i_load    - reload the countdown with DWELL
//   i_tick    - decrement by one (saturates at zero)
//   o_expired - high during the last hold cycle
// -----------------------------------------------------------------------------
module sweep_dwell_timer
  import counter_sweep_ctrl_pkg::*;
#(
  parameter int DWELL = DEF_DWELL
) (
  input  logic clk,
  input  logic reset,
  input  logic i_load,
  input  logic i_tick,
  output logic o_expired
);

  localparam int TW = timer_width(DWELL);

  logic [TW-1:0] r_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= TW'(DWELL);
    end else if (i_tick && (r_cnt != '0)) begin
      r_cnt <= r_cnt - TW'(1);
    end
  end

  // Loaded with N on entry, so the Nth hold cycle sees the value 1.
  assign o_expired = (r_cnt <= TW'(1));

endmodule

// File: rtl/counter_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// counter_sweep_ctrl
// Drives an external up/down counter back and forth between two endpoints for
// a programmable number of legs, holding DWELL cycles at each endpoint.
// Ports:
//   clk   - clock, rising edge
//   reset - asynchronous active-low reset
//   bus   - counter_sweep_ctrl_if.slave (request, counter, status signals)
// Parameters:
//   WIDTH - counter value width
//   DWELL - hold cycles at each endpoint (0 = no hold)
// -----------------------------------------------------------------------------
module counter_sweep_ctrl
  import counter_sweep_ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DWELL = DEF_DWELL
) (
  input  logic                  clk,
  input  logic                  reset,
  counter_sweep_ctrl_if.slave   bus
);

  sweep_state_e      r_state;
  sweep_state_e      w_state_next;

  logic [WIDTH-1:0]  r_start_value;
  logic [WIDTH-1:0]  r_origin;
  logic [WIDTH-1:0]  r_target;
  logic [LEGS_W-1:0] r_legs;
  logic [LEGS_W-1:0] r_leg_idx;

  logic              w_at_target;
  logic              w_last_leg;
  logic              w_capture;
  logic              w_leg_advance;
  logic              w_timer_load;
  logic              w_timer_tick;
  logic              w_timer_expired;

  assign w_at_target  = (bus.cnt_count == r_target);
  assign w_last_leg   = (r_leg_idx == r_legs);
  assign w_timer_tick = (r_state == ST_DWELL);

  sweep_dwell_timer #(
    .DWELL (DWELL)
  ) u_dwell_timer (
    .clk       (clk),
    .reset     (reset),
    .i_load    (w_timer_load),
    .i_tick    (w_timer_tick),
    .o_expired (w_timer_expired)
  );

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next  = r_state;
    w_capture     = 1'b0;
    w_leg_advance = 1'b0;
    w_timer_load  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // abort beats a simultaneous start
        if (bus.start && !bus.abort) begin
          w_state_next = ST_LOAD;
          w_capture    = 1'b1;
        end
      end
      ST_LOAD: begin
        w_state_next = bus.abort ? ST_IDLE : ST_RUN;
      end
      ST_RUN: begin
        if (bus.abort) begin
          w_state_next = ST_IDLE;
        end else if (w_at_target) begin
          if (DWELL != 0) begin
            w_state_next = ST_DWELL;
            w_timer_load = 1'b1;
          end else if (w_last_leg) begin
            w_state_next = ST_DONE;
          end else begin
            w_state_next  = ST_RUN;
            w_leg_advance = 1'b1;
          end
        end
      end
      ST_DWELL: begin
        if (bus.abort) begin
          w_state_next = ST_IDLE;
        end else if (w_timer_expired) begin
          if (w_last_leg) begin
            w_state_next = ST_DONE;
          end else begin
            w_state_next  = ST_RUN;
            w_leg_advance = 1'b1;
          end
        end
      end
      ST_DONE: begin
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Captured sweep parameters and leg bookkeeping
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_start_value <= '0;
      r_origin      <= '0;
      r_target      <= '0;
      r_legs        <= '0;
      r_leg_idx     <= '0;
    end else if (w_capture) begin
      r_start_value <= bus.start_value;
      r_origin      <= bus.start_value;
      r_target      <= bus.end_value;
      r_legs        <= bus.legs;
      r_leg_idx     <= '0;
    end else if (w_leg_advance) begin
      // Next leg runs back the other way
      r_origin  <= r_target;
      r_target  <= r_origin;
      r_leg_idx <= r_leg_idx + LEGS_W'(1);
    end
  end

  // Outputs. abort gates the counter strobes so the counter holds its
  // value on the edge that returns the FSM to IDLE.
  always_comb begin
    bus.cnt_set       = (r_state == ST_LOAD) && !bus.abort;
    bus.cnt_set_value = (r_state == ST_LOAD) ? r_start_value : '0;
    // Direction is fixed per leg so the counter never wraps to reach target
    bus.cnt_up_down   = (r_state == ST_RUN) && (r_target >= r_origin);
    bus.cnt_enable    = (r_state == ST_RUN) && !w_at_target && !bus.abort;
    bus.busy          = (r_state != ST_IDLE);
    bus.done          = (r_state == ST_DONE);
    bus.leg_idx       = r_leg_idx;
  end

endmodule

// File: tb/tb_counter_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// tb_counter_sweep_ctrl
// Directed bench for counter_sweep_ctrl (WIDTH=4, DWELL=2). Contains a model of
// the controlled counter that reacts to cnt_set / cnt_enable / cnt_up_down.
// -----------------------------------------------------------------------------
module tb_counter_sweep_ctrl;
  import counter_sweep_ctrl_pkg::*;

  localparam int WIDTH = 4;
  localparam int DWELL = 2;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;

  counter_sweep_ctrl_if #(.WIDTH(WIDTH)) bus ();

  counter_sweep_ctrl #(
    .WIDTH (WIDTH),
    .DWELL (DWELL)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Controlled counter: load has priority over step, steps wrap
  logic [WIDTH-1:0] cnt_model = '0;
  always_ff @(posedge clk) begin
    if (bus.cnt_set)
      cnt_model <= bus.cnt_set_value;
    else if (bus.cnt_enable)
      cnt_model <= bus.cnt_up_down ? cnt_model + 4'd1 : cnt_model - 4'd1;
  end
  assign bus.cnt_count = cnt_model;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".cnt_enable"},    32'(bus.cnt_enable), 0);
    chk({tag, ".cnt_set"},       32'(bus.cnt_set), 0);
    chk({tag, ".cnt_set_value"}, 32'(bus.cnt_set_value), 0);
    chk({tag, ".cnt_up_down"},   32'(bus.cnt_up_down), 0);
    chk({tag, ".busy"},          32'(bus.busy), 0);
    chk({tag, ".done"},          32'(bus.done), 0);
    chk({tag, ".leg_idx"},       32'(bus.leg_idx), 0);
  endtask

  // Issue start from IDLE, check the LOAD cycle, return in first RUN cycle
  task automatic do_start(input int sv, input int ev, input int lg);
    bus.start       = 1'b1;
    bus.start_value = 4'(sv);
    bus.end_value   = 4'(ev);
    bus.legs        = 3'(lg);
    tick();
    bus.start = 1'b0;
    $display("start %0d->%0d legs=%0d", sv, ev, lg);
    chk("load.cnt_set",       32'(bus.cnt_set), 1);
    chk("load.cnt_set_value", 32'(bus.cnt_set_value), 32'(sv));
    chk("load.cnt_enable",    32'(bus.cnt_enable), 0);
    chk("load.busy",          32'(bus.busy), 1);
    tick();
  endtask

  // Walk one leg from 'from' to 'to' (inclusive) then the dwell cycles
  task automatic run_leg(input int from, input int to, input int leg, input int ud);
    int n;
    n = (to >= from) ? (to - from + 1) : (from - to + 1);
    for (int i = 0; i < n; i++) begin
      chk("run.cnt_count",   32'(bus.cnt_count), 32'(ud != 0 ? from + i : from - i));
      chk("run.cnt_enable",  32'(bus.cnt_enable), (i != n - 1) ? 1 : 0);
      chk("run.cnt_set",     32'(bus.cnt_set), 0);
      chk("run.cnt_up_down", 32'(bus.cnt_up_down), 32'(ud));
      chk("run.leg_idx",     32'(bus.leg_idx), 32'(leg));
      chk("run.done",        32'(bus.done), 0);
      tick();
    end
    for (int d = 0; d < DWELL; d++) begin
      chk("dwell.cnt_enable", 32'(bus.cnt_enable), 0);
      chk("dwell.busy",       32'(bus.busy), 1);
      chk("dwell.done",       32'(bus.done), 0);
      chk("dwell.cnt_count",  32'(bus.cnt_count), 32'(to));
      tick();
    end
    $display("leg %0d done %0d->%0d", leg, from, to);
  endtask

  task automatic chk_done(input string tag);
    chk({tag, ".done_pulse"}, 32'(bus.done), 1);
    chk({tag, ".done_busy"},  32'(bus.busy), 1);
    tick();
    chk({tag, ".done_clear"}, 32'(bus.done), 0);
    chk({tag, ".idle_busy"},  32'(bus.busy), 0);
  endtask

  initial begin
    bus.start       = 1'b0;
    bus.start_value = '0;
    bus.end_value   = '0;
    bus.legs        = '0;
    bus.abort       = 1'b0;

    // Reset state
    #3;
    chk_all_zero("reset");
    tick();
    reset = 1'b1;
    tick();
    chk_all_zero("idle");

    // 2 -> 5, one leg
    do_start(2, 5, 0);
    run_leg(2, 5, 0, 1);
    chk_done("t1");

    // 10 -> 15 -> 10 -> 15
    do_start(10, 15, 2);
    run_leg(10, 15, 0, 1);
    run_leg(15, 10, 1, 0);
    run_leg(10, 15, 2, 1);
    chk_done("t2");

    // Equal endpoints
    do_start(7, 7, 0);
    run_leg(7, 7, 0, 1);
    chk_done("t3");

    // Abort during RUN at count 4
    do_start(0, 12, 0);
    for (int i = 0; i < 4; i++) begin
      chk("abort.pre_count", 32'(bus.cnt_count), 32'(i));
      tick();
    end
    bus.abort = 1'b1;
    #1;
    chk("abort.gate_enable", 32'(bus.cnt_enable), 0);
    tick();
    bus.abort = 1'b0;
    chk("abort.busy",      32'(bus.busy), 0);
    chk("abort.done",      32'(bus.done), 0);
    chk("abort.enable",    32'(bus.cnt_enable), 0);
    chk("abort.cnt_count", 32'(bus.cnt_count), 4);
    tick();
    chk("abort.hold_count", 32'(bus.cnt_count), 4);
    chk("abort.no_done",    32'(bus.done), 0);
    $display("abort at count 4");

    // start and abort together in IDLE
    bus.start       = 1'b1;
    bus.abort       = 1'b1;
    bus.start_value = 4'd9;
    tick();
    bus.start = 1'b0;
    bus.abort = 1'b0;
    chk("start_abort.busy",    32'(bus.busy), 0);
    chk("start_abort.cnt_set", 32'(bus.cnt_set), 0);
    $display("start+abort in idle");

    // start pulse while busy is ignored
    do_start(4, 6, 1);
    bus.start       = 1'b1;
    bus.start_value = 4'd9;
    bus.end_value   = 4'd0;
    bus.legs        = 3'd0;
    #1;
    chk("ignore.cnt_set",   32'(bus.cnt_set), 0);
    chk("ignore.cnt_count", 32'(bus.cnt_count), 4);
    chk("ignore.enable",    32'(bus.cnt_enable), 1);
    tick();
    bus.start = 1'b0;
    run_leg(5, 6, 0, 1);
    run_leg(6, 4, 1, 0);
    chk_done("t6");

    // Reset mid-DWELL, then a down sweep
    do_start(1, 3, 0);
    tick();
    tick();
    tick();
    chk("middwell.busy",   32'(bus.busy), 1);
    chk("middwell.enable", 32'(bus.cnt_enable), 0);
    #2;
    reset = 1'b0;
    #1;
    chk_all_zero("async_reset");
    tick();
    reset = 1'b1;
    chk("after_reset.done", 32'(bus.done), 0);
    tick();
    chk_all_zero("after_reset");
    $display("reset mid-dwell");
    do_start(3, 1, 0);
    run_leg(3, 1, 0, 0);
    chk_done("t7");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/counter_sweep_ctrl.md
COUNTER_SWEEP_CTRL -- requirements
Module: counter_sweep_ctrl

Interface
REQ-001 Parameter WIDTH, default 4, SHALL set the counter value width.
REQ-002 Parameter DWELL, default 2, SHALL set the hold cycles at each endpoint (0 = no hold).
REQ-003 clk  in  1  SHALL be the single clock; all state updates on rising edge.
REQ-004 reset  in  1  SHALL be the asynchronous, active-low reset.
REQ-005 start  in  1  SHALL be the sweep request, sampled only in IDLE.
REQ-006 start_value  in  WIDTH  SHALL be the first endpoint, captured on accepted start.
REQ-007 end_value  in  WIDTH  SHALL be the second endpoint, captured on accepted start.
REQ-008 legs  in  3  SHALL be the number of legs minus one (0 = one leg), captured on accepted start.
REQ-009 abort  in  1  SHALL be the synchronous cancel request.
REQ-010 cnt_count  in  WIDTH  SHALL be the current value of the controlled counter.
REQ-011 cnt_enable  out  1  SHALL be the counter step enable.
REQ-012 cnt_set  out  1  SHALL be the counter synchronous load strobe.
REQ-013 cnt_set_value  out  WIDTH  SHALL be the counter load value.
REQ-014 cnt_up_down  out  1  SHALL be the counter direction (1 = up, 0 = down).
REQ-015 busy  out  1  SHALL be high in every state except IDLE.
REQ-016 done  out  1  SHALL be a one-cycle pulse on normal completion.
REQ-017 leg_idx  out  3  SHALL be the index of the current leg.

Function
REQ-018 Controlled counter: set loads in one cycle; enable steps ±1 with wrap; set has priority over enable.
REQ-019 FSM states SHALL be IDLE, LOAD, RUN, DWELL, DONE.
REQ-020 IDLE: start=1 SHALL capture inputs, clear leg_idx, set target=end_value, go LOAD; start outside IDLE SHALL be ignored.
REQ-021 LOAD: cnt_set=1, cnt_set_value=captured start_value for exactly one cycle, then RUN.
REQ-022 RUN: cnt_up_down SHALL be 1 iff target >= leg origin (unsigned); cnt_enable = (cnt_count != target), combinational.
REQ-023 RUN -> DWELL when cnt_count == target (start_value == end_value SHALL reach DWELL after one RUN cycle).
REQ-024 DWELL SHALL hold cnt_enable=0 for DWELL cycles (zero cycles if DWELL=0, i.e. direct transition).
REQ-025 DWELL end: if leg_idx == legs -> DONE; else leg_idx+1, origin/target swap, RUN.
REQ-026 DONE SHALL assert done for one cycle, then IDLE; busy low same cycle as IDLE entry.
REQ-027 abort in any non-IDLE state SHALL force IDLE next edge; done SHALL NOT pulse; counter value left as is.
REQ-028 abort and start together in IDLE: abort SHALL win (start ignored).
REQ-029 cnt_set and cnt_enable SHALL never be high in the same cycle.
REQ-030 Counter travels shortest monotonic path only; no wrap-around SHALL be used to reach target.

Reset
REQ-031 reset low SHALL immediately force IDLE, cnt_enable=0, cnt_set=0, cnt_set_value=0, cnt_up_down=0, busy=0, done=0, leg_idx=0, dwell timer=0, captured registers=0.
REQ-032 Reset mid-sweep SHALL abandon the sweep with no done pulse.

Structure
REQ-033 Shared package SHALL hold the FSM state enum and DWELL/WIDTH defaults.
REQ-034 Dwell countdown SHALL be a sub-module named sweep_dwell_timer (load, tick, expired).

Verification
REQ-035 start 2->5, legs=0, DWELL=2 -> LOAD 1 cycle, count 2,3,4,5 up, 2 dwell cycles, done one pulse, busy low.
REQ-036 start 10->15, legs=2 -> legs 10->15, 15->10, 10->15; leg_idx 0,1,2; cnt_up_down 1,0,1; single done.
REQ-037 start 7->7, legs=0 -> no cnt_enable high, DWELL then done.
REQ-038 abort during RUN of 0->12 at count 4 -> IDLE next cycle, cnt_enable=0, count stays 4, no done.
REQ-039 reset low mid-DWELL -> all outputs 0 asynchronously; later start 3->1 -> count 3,2,1 down, done.
REQ-040 start pulsed while busy -> ignored; captured values and leg_idx unchanged.
